// File: rtl/hdmi_timing_gen.sv
// Raster timing generator for the AD9889B HDMI transmitter: HS/VS/DE plus FIFO-fed RGB.
// Optional colour-bar test pattern is enabled by defining HDMI_TIMING_TPG_EN.
module hdmi_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEnable,
  input  logic        iGo,
  input  logic [23:0] ivRGB,
  input  logic        iFifoEmpty,
  input  logic        iClearErr,
`ifdef HDMI_TIMING_TPG_EN
  input  logic        iTpgSel,
`endif
  output logic        oFifoReadEn,
  output logic [7:0]  ovR,
  output logic [7:0]  ovG,
  output logic [7:0]  ovB,
  output logic        oHS,
  output logic        oVS,
  output logic        oDE,
  output logic [11:0] ovHcounter,
  output logic [10:0] ovVcounter,
  output logic        oUnderflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] HC_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] HC_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VC_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] VC_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [11:0] r_hc;
  logic [11:0] w_hc_next;
  logic [10:0] r_vc;
  logic [10:0] w_vc_next;
  logic        r_stop;
  logic        w_stop_next;

  logic        w_tpg;
  logic        w_run_next;
  logic        w_act_next;
  logic        w_hs_next;
  logic        w_vs_next;

  // Stage-0 registered decode, aligned with r_hc/r_vc
  logic        r_rd0;
  logic        r_act0;
  logic        r_hs0;
  logic        r_vs0;

  // Stage-1 outputs
  logic        r_de;
  logic        r_hs;
  logic        r_vs;
  logic [23:0] r_rgb;
  logic [23:0] w_rgb_next;
  logic        r_uf;
  logic        w_uf_set;

`ifdef HDMI_TIMING_TPG_EN
  localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);
  logic        r_tpg0;
  logic [2:0]  r_bar0;
  logic [2:0]  w_bar_next;
  assign w_tpg      = iTpgSel;
  assign w_bar_next = 3'(w_hc_next / BAR_W);
`else
  assign w_tpg = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_hc_next    = r_hc;
    w_vc_next    = r_vc;
    w_stop_next  = r_stop;
    case (r_state)
      S_IDLE: begin
        w_hc_next   = '0;
        w_vc_next   = '0;
        w_stop_next = 1'b0;
        if (iEnable) begin
          w_state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        w_hc_next = '0;
        w_vc_next = '0;
        if (iGo || w_tpg) begin
          w_state_next = S_RUN;
        end else if (!iEnable) begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        // A dropped enable is remembered so the frame always completes
        if (!iEnable) begin
          w_stop_next = 1'b1;
        end
        if (r_hc == HC_LAST) begin
          w_hc_next = '0;
          if (r_vc == VC_LAST) begin
            w_vc_next = '0;
            if (r_stop || !iEnable) begin
              w_state_next = S_IDLE;
              w_stop_next  = 1'b0;
            end
          end else begin
            w_vc_next = r_vc + 11'd1;
          end
        end else begin
          w_hc_next = r_hc + 12'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_hc_next    = '0;
        w_vc_next    = '0;
        w_stop_next  = 1'b0;
      end
    endcase
  end

  assign w_run_next = (w_state_next == S_RUN);
  assign w_act_next = w_run_next && (w_hc_next < HC_ACT) && (w_vc_next < VC_ACT);
  assign w_hs_next  = w_run_next && (w_hc_next >= HS_BEG) && (w_hc_next < HS_END);
  assign w_vs_next  = w_run_next && (w_vc_next >= VS_BEG) && (w_vc_next < VS_END);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= S_IDLE;
      r_hc    <= '0;
      r_vc    <= '0;
      r_stop  <= 1'b0;
      r_rd0   <= 1'b0;
      r_act0  <= 1'b0;
      r_hs0   <= 1'b0;
      r_vs0   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_hc    <= w_hc_next;
      r_vc    <= w_vc_next;
      r_stop  <= w_stop_next;
      r_rd0   <= w_act_next && !w_tpg;
      r_act0  <= w_act_next;
      r_hs0   <= w_hs_next;
      r_vs0   <= w_vs_next;
    end
  end

`ifdef HDMI_TIMING_TPG_EN
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_tpg0 <= 1'b0;
      r_bar0 <= '0;
    end else begin
      r_tpg0 <= w_tpg;
      r_bar0 <= w_bar_next;
    end
  end
`endif

  // An empty FIFO on a read still produces a (black) pixel so DE timing never slips
  always_comb begin
    w_rgb_next = '0;
    if (r_act0 && (r_state == S_RUN) && !iFifoEmpty) begin
      w_rgb_next = ivRGB;
    end
`ifdef HDMI_TIMING_TPG_EN
    if (r_act0 && (r_state == S_RUN) && r_tpg0) begin
      w_rgb_next = {{8{~r_bar0[1]}}, {8{~r_bar0[2]}}, {8{~r_bar0[0]}}};
    end
`endif
  end

  assign w_uf_set = r_rd0 && iFifoEmpty;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_de  <= 1'b0;
      r_hs  <= SYNC_OFF;
      r_vs  <= SYNC_OFF;
      r_rgb <= '0;
      r_uf  <= 1'b0;
    end else begin
      r_de  <= r_act0 && (r_state == S_RUN);
      r_hs  <= (r_hs0 && (r_state == S_RUN)) ? SYNC_ON : SYNC_OFF;
      r_vs  <= (r_vs0 && (r_state == S_RUN)) ? SYNC_ON : SYNC_OFF;
      r_rgb <= w_rgb_next;
      if (w_uf_set) begin
        r_uf <= 1'b1;
      end else if (iClearErr) begin
        r_uf <= 1'b0;
      end
    end
  end

  assign oFifoReadEn = r_rd0;
  assign ovHcounter  = r_hc;
  assign ovVcounter  = r_vc;
  assign oDE         = r_de;
  assign oHS         = r_hs;
  assign oVS         = r_vs;
  assign ovR         = r_rgb[23:16];
  assign ovG         = r_rgb[15:8];
  assign ovB         = r_rgb[7:0];
  assign oUnderflow  = r_uf;

endmodule
